// File: rtl/bram_arb2.sv
// Two-requester arbiter in front of a single BRAM port with round-robin grants,
// credit-based read admission and a 2-entry response FIFO per requester.
module bram_arb2 #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int WE_WIDTH   = 4,
    parameter int PIPELINED  = 0
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  r0_req_valid,
    output logic                  r0_req_ready,
    input  logic [WE_WIDTH-1:0]   r0_req_we,
    input  logic [ADDR_WIDTH-1:0] r0_req_addr,
    input  logic [DATA_WIDTH-1:0] r0_req_data,
    output logic                  r0_resp_valid,
    input  logic                  r0_resp_ready,
    output logic [DATA_WIDTH-1:0] r0_resp_data,

    input  logic                  r1_req_valid,
    output logic                  r1_req_ready,
    input  logic [WE_WIDTH-1:0]   r1_req_we,
    input  logic [ADDR_WIDTH-1:0] r1_req_addr,
    input  logic [DATA_WIDTH-1:0] r1_req_data,
    output logic                  r1_resp_valid,
    input  logic                  r1_resp_ready,
    output logic [DATA_WIDTH-1:0] r1_resp_data,

    output logic                  bram_en,
    output logic [WE_WIDTH-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam int L = 1 + PIPELINED;

    logic                  w_req_valid [2];
    logic                  w_is_read   [2];
    logic                  w_resp_rdy  [2];
    logic [1:0]            w_inflight  [2];
    logic                  w_elig      [2];
    logic                  w_grant     [2];
    logic                  w_push      [2];
    logic                  w_pop       [2];
    logic                  w_sel;
    logic                  w_issue_rd;
    logic                  w_cap;
    logic                  w_cap_id;

    logic                  r_pipe_vld  [L];
    logic                  r_pipe_id   [L];
    logic                  r_last_grant;
    logic [1:0]            r_count     [2];
    logic                  r_wptr      [2];
    logic                  r_rptr      [2];
    logic [DATA_WIDTH-1:0] r_mem       [2][2];

    assign w_req_valid[0] = r0_req_valid;
    assign w_req_valid[1] = r1_req_valid;
    assign w_is_read[0]   = (r0_req_we == '0);
    assign w_is_read[1]   = (r1_req_we == '0);
    assign w_resp_rdy[0]  = r0_resp_ready;
    assign w_resp_rdy[1]  = r1_resp_ready;

    // A read holds a credit from grant until its data lands in the buffer,
    // so occupancy plus in-flight never exceeds the buffer depth.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_inflight[n] = '0;
            for (int s = 0; s < L; s++) begin
                if (r_pipe_vld[s] && (r_pipe_id[s] == n[0])) begin
                    w_inflight[n] = w_inflight[n] + 2'd1;
                end
            end
            w_elig[n] = w_req_valid[n] && !RST &&
                        (!w_is_read[n] ||
                         (({1'b0, r_count[n]} + {1'b0, w_inflight[n]}) < 3'd2));
        end
    end

    // r_last_grant=1 means requester 1 was served last, so requester 0 wins a tie.
    assign w_grant[0] = w_elig[0] && (!w_elig[1] || r_last_grant);
    assign w_grant[1] = w_elig[1] && (!w_elig[0] || !r_last_grant);

    assign r0_req_ready = w_grant[0];
    assign r1_req_ready = w_grant[1];

    assign w_sel      = w_grant[1];
    assign bram_en    = w_grant[0] || w_grant[1];
    assign bram_we    = !bram_en ? '0 : (w_sel ? r1_req_we : r0_req_we);
    assign bram_addr  = w_sel ? r1_req_addr : r0_req_addr;
    assign bram_din   = w_sel ? r1_req_data : r0_req_data;
    assign w_issue_rd = bram_en && (w_sel ? w_is_read[1] : w_is_read[0]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < L; s++) begin
                r_pipe_vld[s] <= 1'b0;
                r_pipe_id[s]  <= 1'b0;
            end
        end else begin
            r_pipe_vld[0] <= w_issue_rd;
            r_pipe_id[0]  <= w_sel;
            for (int s = 1; s < L; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_id[s]  <= r_pipe_id[s-1];
            end
        end
    end

    assign w_cap    = r_pipe_vld[L-1];
    assign w_cap_id = r_pipe_id[L-1];

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_push[n] = w_cap && (w_cap_id == n[0]);
            w_pop[n]  = (r_count[n] != 2'd0) && w_resp_rdy[n];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last_grant <= 1'b1;
            for (int n = 0; n < 2; n++) begin
                r_count[n] <= 2'd0;
                r_wptr[n]  <= 1'b0;
                r_rptr[n]  <= 1'b0;
            end
        end else begin
            if (bram_en) begin
                r_last_grant <= w_sel;
            end
            for (int n = 0; n < 2; n++) begin
                if (w_push[n]) begin
                    r_wptr[n] <= ~r_wptr[n];
                end
                if (w_pop[n]) begin
                    r_rptr[n] <= ~r_rptr[n];
                end
                case ({w_push[n], w_pop[n]})
                    2'b10:   r_count[n] <= r_count[n] + 2'd1;
                    2'b01:   r_count[n] <= r_count[n] - 2'd1;
                    default: r_count[n] <= r_count[n];
                endcase
            end
        end
    end

    // Buffer storage needs no reset; validity is carried by r_count.
    always_ff @(posedge CLK) begin
        for (int n = 0; n < 2; n++) begin
            if (w_push[n]) begin
                r_mem[n][r_wptr[n]] <= bram_dout;
            end
        end
    end

    assign r0_resp_valid = (r_count[0] != 2'd0);
    assign r1_resp_valid = (r_count[1] != 2'd0);
    assign r0_resp_data  = r_mem[0][r_rptr[0]];
    assign r1_resp_data  = r_mem[1][r_rptr[1]];

endmodule
